// File: rtl/audio_soft_mute_gain.sv
// audio_soft_mute_gain
//   Stereo gain / soft-mute stage. Each accepted sample is multiplied by the
//   currently applied gain (unity = 2^(gain_width-1)) and saturated. The
//   applied gain walks toward its target (0 when muted, otherwise `gain`) by
//   ramp_step once per stereo frame, so gain changes never click.
//
// Ports
//   clk, nreset        processing clock, asynchronous active-low reset
//   mute, gain         target control (mute forces target 0)
//   i_valid/i_ready    upstream handshake, i_is_left / i_audio payload
//   o_valid/o_ready    downstream handshake, o_is_left / o_audio payload
//   is_muted           high while the applied gain is 0
module audio_soft_mute_gain #(
  parameter int audio_width = 16,
  parameter int gain_width  = 8,
  parameter int ramp_step   = 1
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   mute,
  input  logic [gain_width-1:0]  gain,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_is_left,
  input  logic [audio_width-1:0] i_audio,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   o_is_left,
  output logic [audio_width-1:0] o_audio,
  output logic                   is_muted
);

  localparam int PW = audio_width + gain_width + 1;
  localparam logic [gain_width:0] STEP_C = (gain_width + 1)'(ramp_step);
  localparam logic signed [PW-1:0] SAT_MAX =
    {{(PW - audio_width + 1){1'b0}}, {(audio_width - 1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN =
    {{(PW - audio_width + 1){1'b1}}, {(audio_width - 1){1'b0}}};

  typedef enum logic [1:0] {
    RAMP_HOLD = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_dir_e;

  // Clamp a full-precision scaled value into the sample range.
  function automatic logic [audio_width-1:0] sat_fn(input logic signed [PW-1:0] v);
    logic [audio_width-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[audio_width-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[audio_width-1:0];
    end else begin
      r = v[audio_width-1:0];
    end
    return r;
  endfunction

  logic                   o_valid_q, o_valid_d;
  logic                   o_is_left_q, o_is_left_d;
  logic [audio_width-1:0] o_audio_q, o_audio_d;
  logic [gain_width-1:0]  cur_gain_q, cur_gain_d;
  logic                   is_muted_q, is_muted_d;

  logic                   accept_s, fire_s;
  logic [gain_width-1:0]  target_s, ramp_next_s;
  logic [gain_width:0]    up_sum_s;
  logic [gain_width:0]    down_gap_s;
  ramp_dir_e              ramp_dir_s;
  logic signed [PW-1:0]   audio_ext_s, gain_ext_s, prod_s, shifted_s;

  assign i_ready  = !o_valid_q || o_ready;
  assign accept_s = i_valid && i_ready;
  assign fire_s   = o_valid_q && o_ready;

  // Scale the incoming sample by the gain in force before any update.
  always_comb begin
    audio_ext_s = {{(gain_width + 1){i_audio[audio_width-1]}}, i_audio};
    gain_ext_s  = {{audio_width{1'b0}}, cur_gain_q};
    prod_s      = audio_ext_s * gain_ext_s;
    shifted_s   = prod_s >>> (gain_width - 1);
  end

  // Next applied gain: one bounded step toward the target, never past it.
  always_comb begin
    target_s    = mute ? {gain_width{1'b0}} : gain;
    up_sum_s    = {1'b0, cur_gain_q} + STEP_C;
    down_gap_s  = {1'b0, cur_gain_q - target_s};
    ramp_next_s = cur_gain_q;
    if (cur_gain_q < target_s) begin
      ramp_dir_s = RAMP_UP;
    end else if (cur_gain_q > target_s) begin
      ramp_dir_s = RAMP_DOWN;
    end else begin
      ramp_dir_s = RAMP_HOLD;
    end
    case (ramp_dir_s)
      RAMP_UP: begin
        if (up_sum_s >= {1'b0, target_s}) begin
          ramp_next_s = target_s;
        end else begin
          ramp_next_s = up_sum_s[gain_width-1:0];
        end
      end
      RAMP_DOWN: begin
        if (down_gap_s <= STEP_C) begin
          ramp_next_s = target_s;
        end else begin
          ramp_next_s = cur_gain_q - STEP_C[gain_width-1:0];
        end
      end
      default: ramp_next_s = cur_gain_q;
    endcase
    // Only an accepted right sample closes a frame and moves the gain.
    if (accept_s && !i_is_left) begin
      cur_gain_d = ramp_next_s;
    end else begin
      cur_gain_d = cur_gain_q;
    end
    is_muted_d = (cur_gain_d == {gain_width{1'b0}});
  end

  // Output register stage: load on accept, drain on fire, else hold.
  always_comb begin
    o_valid_d   = o_valid_q;
    o_is_left_d = o_is_left_q;
    o_audio_d   = o_audio_q;
    if (accept_s) begin
      o_valid_d   = 1'b1;
      o_is_left_d = i_is_left;
      o_audio_d   = sat_fn(shifted_s);
    end else if (fire_s) begin
      o_valid_d   = 1'b0;
    end else begin
      o_valid_d   = o_valid_q;
    end
  end

  // State registers; reset starts from silence so the output fades in.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      o_valid_q   <= 1'b0;
      o_is_left_q <= 1'b0;
      o_audio_q   <= {audio_width{1'b0}};
      cur_gain_q  <= {gain_width{1'b0}};
      is_muted_q  <= 1'b1;
    end else begin
      o_valid_q   <= o_valid_d;
      o_is_left_q <= o_is_left_d;
      o_audio_q   <= o_audio_d;
      cur_gain_q  <= cur_gain_d;
      is_muted_q  <= is_muted_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_is_left = o_is_left_q;
  assign o_audio   = o_audio_q;
  assign is_muted  = is_muted_q;

endmodule

// File: tb/tb_audio_soft_mute_gain.sv
// Directed bench for audio_soft_mute_gain. Two instances share the stream:
// dut1 ramps by 1 per frame, dut2 by 4 per frame (used for the mute ramp).
module tb_audio_soft_mute_gain;

  logic        clk = 1'b0;
  logic        nreset;
  logic        mute1, mute2;
  logic [7:0]  gain1, gain2;
  logic        i_valid, i_is_left, o_ready;
  logic [15:0] i_audio;
  logic        i_ready1, o_valid1, o_is_left1, is_muted1;
  logic [15:0] o_audio1;
  logic        i_ready2, o_valid2, o_is_left2, is_muted2;
  logic [15:0] o_audio2;

  int errors_cnt = 0;
  int checks_cnt = 0;

  // Free-running processing clock.
  always #5 clk = ~clk;

  audio_soft_mute_gain #(.audio_width(16), .gain_width(8), .ramp_step(1)) dut1 (
    .clk(clk), .nreset(nreset), .mute(mute1), .gain(gain1),
    .i_valid(i_valid), .i_ready(i_ready1), .i_is_left(i_is_left), .i_audio(i_audio),
    .o_valid(o_valid1), .o_ready(o_ready), .o_is_left(o_is_left1), .o_audio(o_audio1),
    .is_muted(is_muted1)
  );

  audio_soft_mute_gain #(.audio_width(16), .gain_width(8), .ramp_step(4)) dut2 (
    .clk(clk), .nreset(nreset), .mute(mute2), .gain(gain2),
    .i_valid(i_valid), .i_ready(i_ready2), .i_is_left(i_is_left), .i_audio(i_audio),
    .o_valid(o_valid2), .o_ready(o_ready), .o_is_left(o_is_left2), .o_audio(o_audio2),
    .is_muted(is_muted2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one sample, let it be accepted, sample outputs 1 time unit later.
  task automatic send(input logic l, input logic [15:0] a);
    i_valid   = 1'b1;
    i_is_left = l;
    i_audio   = a;
    @(posedge clk);
    #1;
  endtask

  // Reference: (x * g) >>> 7, saturated to 16 bits.
  function automatic logic [15:0] scale(input logic signed [15:0] x, input int g);
    int p;
    p = x * g;
    p = p >>> 7;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  initial begin
    int g;
    nreset = 1'b0; mute1 = 1'b0; mute2 = 1'b0; gain1 = 8'd128; gain2 = 8'd128;
    i_valid = 1'b0; i_is_left = 1'b0; i_audio = 16'h0000; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_o_valid", o_valid1, 1'b0);
    check_eq("rst_o_audio", o_audio1, 16'h0000);
    check_eq("rst_o_is_left", o_is_left1, 1'b0);
    check_eq("rst_is_muted", is_muted1, 1'b1);
    check_eq("rst_i_ready", i_ready1, 1'b1);
    nreset = 1'b1;

    // Fade-in from reset with unity target.
    for (int n = 0; n < 130; n++) begin
      g = (n > 128) ? 128 : n;
      send(1'b1, 16'h1234);
      check_eq("fade_L", o_audio1, scale(16'sh1234, g));
      check_eq("fade_L_flag", o_is_left1, 1'b1);
      if (n == 0) check_eq("fade_muted_before_R", is_muted1, 1'b1);
      if (n == 64) check_eq("fade_hand64", o_audio1, 16'h091A);
      if (n == 127) check_eq("fade_hand127", o_audio1, 16'h120F);
      if (n == 129) check_eq("fade_unity", o_audio1, 16'h1234);
      send(1'b0, 16'h1234);
      check_eq("fade_R", o_audio1, scale(16'sh1234, g));
      if (n == 0) check_eq("fade_unmuted_after_R", is_muted1, 1'b0);
    end

    // Soft mute on dut2 (step 4); input 0x0080 makes output equal the gain.
    mute2 = 1'b1;
    for (int k = 0; k < 34; k++) begin
      g = (128 - 4 * k < 0) ? 0 : 128 - 4 * k;
      send(1'b1, 16'h0080);
      check_eq("mute_L", o_audio2, g);
      send(1'b0, 16'h0080);
      check_eq("mute_R", o_audio2, g);
      check_eq("mute_is_muted", is_muted2, (k >= 31) ? 1'b1 : 1'b0);
    end
    check_eq("mute_out_zero", o_audio2, 16'h0000);

    // Ramp dut1 to full scale, then saturation vectors on left-only samples.
    gain1 = 8'd255;
    for (int k = 0; k < 130; k++) begin
      send(1'b1, 16'h0000);
      send(1'b0, 16'h0000);
    end
    send(1'b1, 16'h4000); check_eq("sat_4000", o_audio1, 16'h7F80);
    send(1'b1, 16'h6000); check_eq("sat_6000", o_audio1, 16'h7FFF);
    send(1'b1, 16'h7FFF); check_eq("sat_7FFF", o_audio1, 16'h7FFF);
    send(1'b1, 16'h8000); check_eq("sat_8000", o_audio1, 16'h8000);
    send(1'b1, 16'hFFFF); check_eq("sat_FFFF", o_audio1, 16'hFFFE);

    // Backpressure: A held while B waits, then B then C in order.
    send(1'b1, 16'h0100);
    check_eq("stall_A", o_audio1, 16'h01FE);
    o_ready = 1'b0;
    i_valid = 1'b1; i_is_left = 1'b0; i_audio = 16'h0200;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("stall_i_ready", i_ready1, 1'b0);
      @(posedge clk);
      #1;
      check_eq("stall_hold_audio", o_audio1, 16'h01FE);
      check_eq("stall_hold_flag", o_is_left1, 1'b1);
      check_eq("stall_hold_valid", o_valid1, 1'b1);
    end
    o_ready = 1'b1;
    #1;
    check_eq("stall_release_ready", i_ready1, 1'b1);
    send(1'b0, 16'h0200);
    check_eq("stall_B", o_audio1, 16'h03FC);
    check_eq("stall_B_flag", o_is_left1, 1'b0);
    send(1'b1, 16'h0080);
    check_eq("stall_C", o_audio1, 16'h00FF);

    // Asynchronous reset while holding a valid sample.
    check_eq("arst_pre_valid", o_valid1, 1'b1);
    nreset = 1'b0;
    #1;
    check_eq("arst_o_valid", o_valid1, 1'b0);
    check_eq("arst_is_muted", is_muted1, 1'b1);
    check_eq("arst_o_audio", o_audio1, 16'h0000);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    gain1 = 8'd128;
    send(1'b1, 16'h1234); check_eq("arst_first_L", o_audio1, 16'h0000);
    send(1'b0, 16'h1234); check_eq("arst_first_R", o_audio1, 16'h0000);

    // Climb to 110, then retarget to 100 mid-ramp.
    for (int k = 0; k < 109; k++) begin
      send(1'b1, 16'h0080);
      send(1'b0, 16'h0080);
    end
    send(1'b1, 16'h0080);
    check_eq("retgt_at110", o_audio1, 16'h006E);
    gain1 = 8'd100;
    send(1'b0, 16'h0080);
    check_eq("retgt_R110", o_audio1, 16'h006E);
    for (int j = 0; j < 14; j++) begin
      g = (109 - j < 100) ? 100 : 109 - j;
      send(1'b1, 16'h0080);
      check_eq("retgt_L", o_audio1, g);
      send(1'b0, 16'h0080);
      check_eq("retgt_R", o_audio1, g);
    end

    // Left-only stream must not move the gain even with a new target.
    gain1 = 8'd120;
    for (int k = 0; k < 10; k++) begin
      send(1'b1, 16'h0080);
      check_eq("leftonly", o_audio1, 16'h0064);
    end
    send(1'b0, 16'h0080);
    check_eq("leftonly_R", o_audio1, 16'h0064);
    send(1'b1, 16'h0080);
    check_eq("leftonly_next", o_audio1, 16'h0065);
    i_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
